// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode and FSM state encodings.
// No ports; imported by alu_multicycle and alu_iter_unit.
package alu_pkg;

  localparam int unsigned SEL_W = 5;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_ADC = 5'd2,
    OP_LS  = 5'd3,
    OP_RS  = 5'd4,
    OP_AND = 5'd5,
    OP_OR  = 5'd6,
    OP_XOR = 5'd7,
    OP_SBB = 5'd8,
    OP_MUL = 5'd9,
    OP_DIV = 5'd10
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared one-bit-per-cycle datapath for unsigned shift-add multiply and
// restoring divide.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture operands and clear accumulator/counter
//   step          perform one iteration
//   mode          MUL_RUN or DIV_RUN; selects operand routing and iteration
//   a, b          operands (a = multiplicand/dividend, b = multiplier/divisor)
//   lo_next_c     low half after the current iteration (product lo / quotient)
//   hi_next_c     high half after the current iteration (product hi / remainder)
//   last_c        current iteration is the final one
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  state_e               mode,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic [DATA_SIZE-1:0] lo_next_c,
  output logic [DATA_SIZE-1:0] hi_next_c,
  output logic                 last_c
);

  localparam int unsigned W     = DATA_SIZE;
  localparam int unsigned CNT_W = $clog2(DATA_SIZE) + 1;

  logic [W-1:0]     acc_q;   // product high half / partial remainder
  logic [W-1:0]     shr_q;   // multiplier bits / dividend-then-quotient bits
  logic [W-1:0]     opnd_q;  // multiplicand or divisor
  logic [CNT_W-1:0] cnt_q;

  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] trial;
  logic         fits;

  // One iteration of either algorithm, selected by mode
  always_comb begin
    sum       = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
    shifted   = {acc_q, shr_q[W-1]};
    fits      = (shifted >= {1'b0, opnd_q});
    // Only used when fits, so the true difference is below 2^W
    trial     = shifted[W-1:0] - opnd_q;
    lo_next_c = {sum[0], shr_q[W-1:1]};
    hi_next_c = sum[W:1];
    if (mode == DIV_RUN) begin
      lo_next_c = {shr_q[W-2:0], fits};
      hi_next_c = fits ? trial : shifted[W-1:0];
    end
  end

  assign last_c = (cnt_q == CNT_W'(DATA_SIZE - 1));

  // Operand capture and iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      shr_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      shr_q  <= (mode == DIV_RUN) ? a : b;
      opnd_q <= (mode == DIV_RUN) ? b : a;
    end else if (step) begin
      acc_q <= hi_next_c;
      shr_q <= lo_next_c;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// ALU with single-cycle arithmetic/logic ops and multi-cycle MUL/DIV.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          operation request, taken only when not busy
//   select         opcode (alu_pkg::opcode_e); unknown codes pass A through
//   A, B           operands, sampled on the accepted start edge
//   op_enable      drives out when 1, out is high-impedance when 0
//   out            low result (quotient for DIV)
//   out_hi         MUL high half / DIV remainder, 0 otherwise
//   busy           MUL/DIV iteration in progress
//   done           one-cycle pulse when result and flags update
//   flag_*         zero, carry, negative, signed overflow, divide-by-zero
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_W-1:0]     select,
  input  logic [DATA_SIZE-1:0] A,
  input  logic [DATA_SIZE-1:0] B,
  input  logic                 op_enable,
  output logic [DATA_SIZE-1:0] out,
  output logic [DATA_SIZE-1:0] out_hi,
  output logic                 busy,
  output logic                 done,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 flag_neg,
  output logic                 flag_ovf,
  output logic                 flag_div0
);

  localparam int unsigned W   = DATA_SIZE;
  localparam int unsigned MSB = DATA_SIZE - 1;

  state_e state_q, state_d;

  logic [W-1:0] result_q, hi_q;
  logic         done_q, zero_q, carry_q, neg_q, ovf_q, div0_q;

  opcode_e sel_c;
  logic    accept_c, iter_start_c, single_c, fin_c, step_c;
  state_e  iter_mode_c;

  logic [W-1:0] lo_next_c, hi_next_c;
  logic         last_c;

  logic         cin_c;
  logic [W:0]   add_c, sub_c;
  logic [W-1:0] alu_res_c, alu_hi_c;
  logic         alu_carry_c, alu_ovf_c, alu_div0_c;

  logic [W-1:0] new_res_c, new_hi_c;
  logic         new_carry_c, new_ovf_c, new_div0_c;

  assign sel_c        = opcode_e'(select);
  // A start coinciding with reset is dropped here rather than in the FSM
  assign accept_c     = start && !rst && (state_q == IDLE);
  assign iter_start_c = accept_c && ((sel_c == OP_MUL) || ((sel_c == OP_DIV) && (B != '0)));
  assign single_c     = accept_c && !iter_start_c;
  assign fin_c        = (state_q != IDLE) && last_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (iter_start_c) state_d = (sel_c == OP_MUL) ? MUL_RUN : DIV_RUN;
      MUL_RUN, DIV_RUN: if (last_c)       state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy        = (state_q != IDLE);
    step_c      = (state_q != IDLE);
    // On load the iteration unit needs the mode being entered
    iter_mode_c = iter_start_c ? state_d : state_q;
  end

  alu_iter_unit #(.DATA_SIZE(DATA_SIZE)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (iter_start_c),
    .step      (step_c),
    .mode      (iter_mode_c),
    .a         (A),
    .b         (B),
    .lo_next_c (lo_next_c),
    .hi_next_c (hi_next_c),
    .last_c    (last_c)
  );

  // Single-cycle operations; MUL never lands here and DIV only with B == 0
  always_comb begin
    cin_c       = ((sel_c == OP_ADC) || (sel_c == OP_SBB)) ? carry_q : 1'b0;
    add_c       = {1'b0, A} + {1'b0, B} + (W+1)'(cin_c);
    sub_c       = {1'b0, A} - {1'b0, B} - (W+1)'(cin_c);
    alu_res_c   = A;
    alu_hi_c    = '0;
    alu_carry_c = carry_q;
    alu_ovf_c   = 1'b0;
    alu_div0_c  = 1'b0;
    case (sel_c)
      OP_ADD, OP_ADC: begin
        alu_res_c   = add_c[W-1:0];
        alu_carry_c = add_c[W];
        alu_ovf_c   = (A[MSB] == B[MSB]) && (add_c[MSB] != A[MSB]);
      end
      OP_SUB, OP_SBB: begin
        alu_res_c   = sub_c[W-1:0];
        alu_carry_c = sub_c[W];  // borrow: A < B + cin
        alu_ovf_c   = (A[MSB] != B[MSB]) && (sub_c[MSB] != A[MSB]);
      end
      OP_LS: begin
        alu_res_c   = {A[MSB-1:0], 1'b0};
        alu_carry_c = A[MSB];
      end
      OP_RS: begin
        alu_res_c   = {1'b0, A[MSB:1]};
        alu_carry_c = A[0];
      end
      OP_AND: alu_res_c = A & B;
      OP_OR:  alu_res_c = A | B;
      OP_XOR: alu_res_c = A ^ B;
      OP_DIV: begin
        alu_res_c  = '1;
        alu_hi_c   = A;
        alu_div0_c = 1'b1;
      end
      default: alu_res_c = A;
    endcase
  end

  // Values committed on the done edge
  always_comb begin
    new_res_c   = lo_next_c;
    new_hi_c    = hi_next_c;
    new_carry_c = (state_q == MUL_RUN) ? (hi_next_c != '0) : carry_q;
    new_ovf_c   = 1'b0;
    new_div0_c  = 1'b0;
    if (single_c) begin
      new_res_c   = alu_res_c;
      new_hi_c    = alu_hi_c;
      new_carry_c = alu_carry_c;
      new_ovf_c   = alu_ovf_c;
      new_div0_c  = alu_div0_c;
    end
  end

  // Result and flag registers, touched only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      hi_q     <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= single_c || fin_c;
      if (single_c || fin_c) begin
        result_q <= new_res_c;
        hi_q     <= new_hi_c;
        zero_q   <= (new_res_c == '0);
        neg_q    <= new_res_c[MSB];
        carry_q  <= new_carry_c;
        ovf_q    <= new_ovf_c;
        div0_q   <= new_div0_c;
      end
    end
  end

  assign out        = op_enable ? result_q : 'z;
  assign out_hi     = hi_q;
  assign done       = done_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_neg   = neg_q;
  assign flag_ovf   = ovf_q;
  assign flag_div0  = div0_q;

endmodule
